rvc_fetch_expander: RTL and testbench



---
 rtl/rvc_fetch_expander.sv | 270 +++++++++++++++++++++++++++
 tb/tb_rvc_fetch_expander.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rvc_fetch_expander.sv
// rtl/rvc_fetch_expander.sv - fetch-side RVC realigner/expander with halfword buffer, PC tracking and output queue
//
// Purpose:
//   Accepts 32-bit fetch words and splits them into a 4-entry halfword buffer (HB).
//   Each cycle issues at most one instruction into an output FIFO:
//     - 16-bit encodings are expanded to RV32I.
//     - 32-bit encodings are reassembled, including ones that straddle two fetch words.
//   Every FIFO entry carries its PC, a compressed flag and an illegal flag.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   flush, flush_pc                  redirect: drop HB/FIFO contents, restart at flush_pc
//   in_valid, in_ready, in_data      fetch word stream ([15:0] = lower address halfword)
//   out_valid, out_ready             FIFO head handshake towards decode
//   out_instr, out_pc                32-bit instruction and its PC (zero when the FIFO is empty)
//   out_is_c, out_illegal            compressed-origin flag, unsupported/illegal RVC flag
//
// Configuration macro:
//   RVC_CTRL_EN   also expands the control-flow and stack-pointer RVC subset:
//                 C.J, C.JAL, C.BEQZ, C.BNEZ, C.MV, C.JR, C.JALR, C.EBREAK,
//                 C.LWSP, C.SWSP, C.ADDI16SP, C.ADDI4SPN.

module rvc_fetch_expander #(
    parameter int PC_W      = 32,
    parameter int OUT_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic [PC_W-1:0] flush_pc,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic            out_is_c,
    output logic            out_illegal
);

`ifdef RVC_CTRL_EN
    localparam bit CTRL_EN = 1'b1;
`else
    localparam bit CTRL_EN = 1'b0;
`endif

    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(OUT_DEPTH);

    // Returns {illegal, instr}. Illegal encodings hand back the raw halfword zero-extended.
    function automatic logic [32:0] rvc_expand(input logic [15:0] c);
        logic [31:0] ins;
        logic        ill;
        logic [4:0]  rd, rs2, rdp, rs1p;
        logic [11:0] joff;
        rd   = c[11:7];
        rs2  = c[6:2];
        rdp  = {2'b01, c[4:2]};
        rs1p = {2'b01, c[9:7]};
        joff = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
        ins  = '0;
        ill  = 1'b0;
        case (c[1:0])
            2'b00: begin
                case (c[15:13])
                    3'b000: begin // C.ADDI4SPN
                        ins = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, 7'h13};
                        ill = !CTRL_EN || (c[12:5] == 8'h00);
                    end
                    3'b010: ins = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, 7'h03};
                    3'b110: ins = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'h23};
                    default: ill = 1'b1;
                endcase
            end
            2'b01: begin
                case (c[15:13])
                    3'b000: ins = {{6{c[12]}}, c[12], c[6:2], rd, 3'b000, rd, 7'h13};
                    3'b001: begin // C.JAL
                        ins = {joff[11], joff[10:1], joff[11], {8{joff[11]}}, 5'd1, 7'h6f};
                        ill = !CTRL_EN;
                    end
                    3'b010: ins = {{6{c[12]}}, c[12], c[6:2], 5'd0, 3'b000, rd, 7'h13};
                    3'b011: begin
                        if (rd == 5'd2) begin // C.ADDI16SP
                            ins = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0000, 5'd2, 3'b000, 5'd2, 7'h13};
                            ill = !CTRL_EN || ({c[12], c[6:2]} == 6'd0);
                        end else begin        // C.LUI
                            ins = {{14{c[12]}}, c[12], c[6:2], rd, 7'h37};
                            ill = (rd == 5'd0) || ({c[12], c[6:2]} == 6'd0);
                        end
                    end
                    3'b100: begin
                        case (c[11:10])
                            2'b00: begin
                                ins = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
                                ill = c[12];
                            end
                            2'b01: begin
                                ins = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
                                ill = c[12];
                            end
                            2'b10: ins = {{6{c[12]}}, c[12], c[6:2], rs1p, 3'b111, rs1p, 7'h13};
                            default: begin
                                // c[12]=1 selects RV64-only register ops
                                ill = c[12];
                                case (c[6:5])
                                    2'b00:   ins = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'h33};
                                    2'b01:   ins = {7'b0000000, rdp, rs1p, 3'b100, rs1p, 7'h33};
                                    2'b10:   ins = {7'b0000000, rdp, rs1p, 3'b110, rs1p, 7'h33};
                                    default: ins = {7'b0000000, rdp, rs1p, 3'b111, rs1p, 7'h33};
                                endcase
                            end
                        endcase
                    end
                    3'b101: begin // C.J
                        ins = {joff[11], joff[10:1], joff[11], {8{joff[11]}}, 5'd0, 7'h6f};
                        ill = !CTRL_EN;
                    end
                    3'b110: begin // C.BEQZ
                        ins = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 3'b000, c[11:10], c[4:3], c[12], 7'h63};
                        ill = !CTRL_EN;
                    end
                    default: begin // C.BNEZ
                        ins = {c[12], {3{c[12]}}, c[6:5], c[2], 5'd0, rs1p, 3'b001, c[11:10], c[4:3], c[12], 7'h63};
                        ill = !CTRL_EN;
                    end
                endcase
            end
            2'b10: begin
                case (c[15:13])
                    3'b000: begin
                        ins = {7'b0000000, c[6:2], rd, 3'b001, rd, 7'h13};
                        ill = c[12];
                    end
                    3'b010: begin // C.LWSP
                        ins = {4'b0000, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'h03};
                        ill = !CTRL_EN || (rd == 5'd0);
                    end
                    3'b100: begin
                        if (!c[12]) begin
                            if (rs2 == 5'd0) begin // C.JR
                                ins = {12'h000, rd, 3'b000, 5'd0, 7'h67};
                                ill = !CTRL_EN || (rd == 5'd0);
                            end else begin          // C.MV
                                ins = {7'b0000000, rs2, 5'd0, 3'b000, rd, 7'h33};
                                ill = !CTRL_EN;
                            end
                        end else if (rs2 == 5'd0) begin
                            if (rd == 5'd0) ins = 32'h0010_0073;                     // C.EBREAK
                            else            ins = {12'h000, rd, 3'b000, 5'd1, 7'h67}; // C.JALR
                            ill = !CTRL_EN;
                        end else begin              // C.ADD
                            ins = {7'b0000000, rs2, rd, 3'b000, rd, 7'h33};
                        end
                    end
                    3'b110: begin // C.SWSP
                        ins = {4'b0000, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'h23};
                        ill = !CTRL_EN;
                    end
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (c == 16'h0000) ill = 1'b1;
        if (ill) ins = {16'h0000, c};
        return {ill, ins};
    endfunction

    logic [3:0][15:0] hb, hb_s, hb_n;
    logic [2:0]       hb_cnt, cnt_pop, cnt_n;
    logic [PC_W-1:0]  head_pc;
    logic             drop_lo;

    logic [31:0]      fifo_instr [OUT_DEPTH];
    logic [PC_W-1:0]  fifo_pc    [OUT_DEPTH];
    logic             fifo_is_c  [OUT_DEPTH];
    logic             fifo_ill   [OUT_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    fifo_cnt;

    logic        accept, deq, fifo_room, is32, issue;
    logic [1:0]  pop;
    logic [32:0] exp_res;
    logic [31:0] iss_instr;
    logic        iss_ill;

    // in_ready is held low throughout reset, not just after it
    assign in_ready  = rst_n & (hb_cnt <= 3'd2) & ~flush;
    assign accept    = in_valid & in_ready;
    assign out_valid = (fifo_cnt != '0);
    assign deq       = out_valid & out_ready;
    // A full FIFO can still take an entry when the head leaves in the same cycle
    assign fifo_room = (fifo_cnt != DEPTH_C) | deq;
    assign is32      = (hb[0][1:0] == 2'b11);
    // A 32-bit instruction with only its low half buffered waits for the next word
    assign issue     = ~flush & fifo_room & (is32 ? (hb_cnt >= 3'd2) : (hb_cnt >= 3'd1));
    assign pop       = issue ? (is32 ? 2'd2 : 2'd1) : 2'd0;
    assign exp_res   = rvc_expand(hb[0]);
    assign iss_instr = is32 ? {hb[1], hb[0]} : exp_res[31:0];
    assign iss_ill   = ~is32 & exp_res[32];

    // Pop first, then append the accepted halfwords behind what remains
    always_comb begin
        hb_s    = hb >> {pop, 4'b0000};
        cnt_pop = hb_cnt - {1'b0, pop};
        hb_n    = hb_s;
        cnt_n   = cnt_pop;
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                if (drop_lo) begin
                    if (3'(i) == cnt_pop) hb_n[i] = in_data[31:16];
                end else begin
                    if (3'(i) == cnt_pop)        hb_n[i] = in_data[15:0];
                    if (3'(i) == cnt_pop + 3'd1) hb_n[i] = in_data[31:16];
                end
            end
            cnt_n = drop_lo ? cnt_pop + 3'd1 : cnt_pop + 3'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb       <= '0;
            hb_cnt   <= '0;
            head_pc  <= '0;
            drop_lo  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            hb_cnt   <= '0;
            head_pc  <= flush_pc & ~PC_W'(1);
            drop_lo  <= flush_pc[1];
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            hb     <= hb_n;
            hb_cnt <= cnt_n;
            if (accept) drop_lo <= 1'b0;
            if (issue)  head_pc <= head_pc + (is32 ? PC_W'(4) : PC_W'(2));
            if (issue)  wr_ptr  <= wr_ptr + PW'(1);
            if (deq)    rd_ptr  <= rd_ptr + PW'(1);
            case ({issue, deq})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Entry storage needs no reset; visibility is governed by fifo_cnt
    always_ff @(posedge clk) begin
        if (issue) begin
            fifo_instr[wr_ptr] <= iss_instr;
            fifo_pc[wr_ptr]    <= head_pc;
            fifo_is_c[wr_ptr]  <= ~is32;
            fifo_ill[wr_ptr]   <= iss_ill;
        end
    end

    assign out_instr   = out_valid ? fifo_instr[rd_ptr] : '0;
    assign out_pc      = out_valid ? fifo_pc[rd_ptr]    : '0;
    assign out_is_c    = out_valid & fifo_is_c[rd_ptr];
    assign out_illegal = out_valid & fifo_ill[rd_ptr];

endmodule

// File: tb/tb_rvc_fetch_expander.sv
// tb/tb_rvc_fetch_expander.sv - scoreboard bench for rvc_fetch_expander

module tb_rvc_fetch_expander;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] flush_pc;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_is_c;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;
    logic [65:0] exp_q [$];
    bit sender_done;

    rvc_fetch_expander #(.PC_W(32), .OUT_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_is_c(out_is_c), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Tuple layout: {illegal, is_c, pc, instr}
    task automatic expect_out(input logic [31:0] instr, input logic [31:0] pc,
                              input logic is_c, input logic ill);
        exp_q.push_back({ill, is_c, pc, instr});
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out got %h/%h expected none", out_pc, out_instr);
            end else begin
                check("out_entry", {out_illegal, out_is_c, out_pc, out_instr}, exp_q.pop_front());
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        int n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout got in_ready=0 expected 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check(name, 66'(exp_q.size()), 66'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; flush_pc = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  66'(in_ready),  66'd0);
        check("rst_out_valid", 66'(out_valid), 66'd0);
        check("rst_out_instr", 66'(out_instr), 66'd0);
        check("rst_out_pc",    66'(out_pc),    66'd0);
        rst_n = 1'b1;

        // 1: reset mid-stream with three queued entries
        send_word(32'h0001_0001);
        send_word(32'h0003_0001);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t1_pre_valid", 66'(out_valid), 66'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_rst_valid",    66'(out_valid), 66'd0);
        check("t1_rst_in_ready", 66'(in_ready),  66'd0);
        check("t1_rst_instr",    66'(out_instr), 66'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        expect_out(32'h0014_0413, 32'h0, 1'b1, 1'b0);
        expect_out(32'h0000_0013, 32'h2, 1'b1, 1'b0);
        send_word(32'h0001_0405);
        drain("t1_drain");

        // 2: 32-bit instruction straddling two fetch words
        do_flush(32'h0);
        expect_out(32'h0014_0413, 32'h0, 1'b1, 1'b0);
        expect_out(32'h0010_0093, 32'h2, 1'b0, 1'b0);
        expect_out(32'h0000_0013, 32'h6, 1'b1, 1'b0);
        send_word(32'h0093_0405);
        send_word(32'h0001_0010);
        drain("t2_drain");

        // 3: backpressure, 16 NOPs held back then released
        do_flush(32'h0);
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) expect_out(32'h0000_0013, 32'(2 * i), 1'b1, 1'b0);
        sender_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 8; k++) send_word(32'h0001_0001);
                sender_done = 1'b1;
            end
        join_none
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("t3_bp_valid",    66'(out_valid), 66'd1);
        check("t3_bp_in_ready", 66'(in_ready),  66'd0);
        check("t3_bp_head_pc",  66'(out_pc),    66'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        begin
            int n = 0;
            while (!sender_done && n < 1000) begin
                @(posedge clk);
                n++;
            end
            check("t3_sender_done", 66'(sender_done), 66'd1);
        end
        #1;
        drain("t3_drain");

        // 4: flush with a non-empty FIFO, odd-halfword target
        do_flush(32'h10);
        out_ready = 1'b0;
        send_word(32'h0001_0001);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t4_pre_valid", 66'(out_valid), 66'd1);
        @(posedge clk);
        #1;
        do_flush(32'h102);
        @(negedge clk);
        check("t4_post_flush_valid", 66'(out_valid), 66'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        expect_out(32'h0014_0413, 32'h102, 1'b1, 1'b0);
        send_word(32'h0405_FFFF);
        drain("t4_drain");

        // 5: all-zero halfword is illegal and does not stall the queue
        do_flush(32'h40);
        expect_out(32'h0000_0000, 32'h40, 1'b1, 1'b1);
        expect_out(32'h0000_0013, 32'h42, 1'b1, 1'b0);
        send_word(32'h0001_0000);
        drain("t5_drain");

        // 6: C.MV depends on the control-subset build option
        do_flush(32'h80);
`ifdef RVC_CTRL_EN
        expect_out(32'h00B0_0533, 32'h80, 1'b1, 1'b0);
`else
        expect_out(32'h0000_852E, 32'h80, 1'b1, 1'b1);
`endif
        expect_out(32'h0000_0013, 32'h82, 1'b1, 1'b0);
        send_word(32'h0001_852E);
        drain("t6_drain");

        // 7: base-set spot checks: C.SUB, C.LW, C.LUI, C.SRLI shamt[5]=1, C.LI negative
        do_flush(32'h200);
        expect_out(32'h4094_0433, 32'h200, 1'b1, 1'b0);
        expect_out(32'h0044_A403, 32'h202, 1'b1, 1'b0);
        expect_out(32'h0000_10B7, 32'h204, 1'b1, 1'b0);
        expect_out(32'h0000_9005, 32'h206, 1'b1, 1'b1);
        expect_out(32'hFFF0_0293, 32'h208, 1'b1, 1'b0);
        expect_out(32'h0000_0013, 32'h20A, 1'b1, 1'b0);
        send_word(32'h40C0_8C05);
        send_word(32'h9005_6085);
        send_word(32'h0001_52FD);
        drain("t7_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
